// File: rtl/cpu_step_controller_pkg.sv
// Shared definitions for the CPU step controller: state encoding and defaults.
package cpu_step_controller_pkg;

    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1000000;
    localparam int unsigned STATE_W                 = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_STEP   = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

endpackage

// File: rtl/cpu_step_controller_button_debouncer.sv
// Button debouncer: 2-FF input synchronizer, then the clean output follows the
// synced input only after CYCLES consecutive samples that differ from it.
module button_debouncer
    import cpu_step_controller_pkg::*;
#(
    parameter int unsigned CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk_in,
    input  logic rst,
    input  logic raw,
    output logic clean
);

    localparam int unsigned CW = $clog2(CYCLES + 1);

    logic          raw_s1;
    logic          raw_s2;
    logic [CW-1:0] cnt;

    // Synchronize the raw button and count how long it disagrees with clean.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            raw_s1 <= 1'b0;
            raw_s2 <= 1'b0;
            cnt    <= '0;
            clean  <= 1'b0;
        end else begin
            raw_s1 <= raw;
            raw_s2 <= raw_s1;
            if (raw_s2 == clean) begin
                cnt <= '0;
            end else if (cnt == CW'(CYCLES - 1)) begin
                clean <= raw_s2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/cpu_step_controller.sv
// CPU step controller: turns slow_clk rising edges into single-cycle cpu_ce
// pulses in run mode, issues one pulse per debounced button press in step mode,
// and locks out the CPU permanently once it reports halt.
module cpu_step_controller
    import cpu_step_controller_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned CNT_W           = 32
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             slow_clk,
    input  logic             mode_run,
    input  logic             step_btn,
    input  logic             halt,
    output logic             cpu_ce,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] step_count
);

    logic   s1;
    logic   s2;
    logic   s3;
    logic   tick;
    logic   db;
    logic   db_q;
    logic   step_req;
    state_t state_q;

    button_debouncer #(
        .CYCLES (DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk_in (clk_in),
        .rst    (rst),
        .raw    (step_btn),
        .clean  (db)
    );

    // slow_clk is data here: synchronize, then keep a delayed copy for edge detect.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            s3   <= 1'b0;
            db_q <= 1'b0;
        end else begin
            s1   <= slow_clk;
            s2   <= s1;
            s3   <= s2;
            db_q <= db;
        end
    end

    assign tick     = s2 & ~s3;
    assign step_req = db & ~db_q;

    // Control FSM; halt outranks every other request, HALTED leaves only via reset.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cpu_ce  <= 1'b0;
        end else begin
            cpu_ce <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (halt) begin
                        state_q <= ST_HALTED;
                    end else if (mode_run) begin
                        state_q <= ST_RUN;
                    end else if (step_req) begin
                        state_q <= ST_STEP;
                        cpu_ce  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (halt) begin
                        state_q <= ST_HALTED;
                    end else if (!mode_run) begin
                        state_q <= ST_IDLE;
                    end else if (tick) begin
                        cpu_ce <= 1'b1;
                    end
                end
                ST_STEP: begin
                    state_q <= halt ? ST_HALTED : ST_IDLE;
                end
                ST_HALTED: begin
                    state_q <= ST_HALTED;
                end
            endcase
        end
    end

    // Count every issued pulse; wraps silently.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            step_count <= '0;
        end else if (cpu_ce) begin
            step_count <= step_count + CNT_W'(1);
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_cpu_step_controller.sv
// Testbench for cpu_step_controller (DEBOUNCE_CYCLES=4, CNT_W=4).
module tb_cpu_step_controller;

    logic       clk_in;
    logic       rst;
    logic       slow_clk;
    logic       mode_run;
    logic       step_btn;
    logic       halt;
    logic       cpu_ce;
    logic [1:0] state;
    logic [3:0] step_count;

    cpu_step_controller #(
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (4)
    ) dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .slow_clk   (slow_clk),
        .mode_run   (mode_run),
        .step_btn   (step_btn),
        .halt       (halt),
        .cpu_ce     (cpu_ce),
        .state      (state),
        .step_count (step_count)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    bit prev_ce = 1'b0;

    always @(posedge clk_in) cyc <= cyc + 1;

    // Expected pulse: acceptable cycle window and the state that must accompany it.
    typedef struct {
        int         lo;
        int         hi;
        logic [1:0] st;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        bit         mode_run;
        bit         halt;
        int         rises;
        bit         press;
        bit         pulses;
        logic [1:0] exp_state;
        logic [3:0] exp_count;
    } vec_t;
    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick_n(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    // One slow_clk period of 20 clk_in cycles; its pulse lands 3 edges after the rise.
    task automatic rise(input bit expect_pulse);
        exp_t e;
        slow_clk = 1'b1;
        if (expect_pulse) begin
            e.lo = cyc + 3; e.hi = cyc + 3; e.st = 2'd1;
            sb.push_back(e);
        end
        tick_n(10);
        slow_clk = 1'b0;
        tick_n(10);
    endtask

    // Bouncing press 1-0-1, held 50 cycles, then released.
    task automatic press(input bit expect_pulse);
        exp_t e;
        step_btn = 1'b1; tick_n(1);
        step_btn = 1'b0; tick_n(1);
        step_btn = 1'b1;
        if (expect_pulse) begin
            e.lo = cyc + 6; e.hi = cyc + 8; e.st = 2'd2;
            sb.push_back(e);
        end
        tick_n(50);
        step_btn = 1'b0;
        tick_n(15);
    endtask

    // Pulse monitor: every cpu_ce pulse must match the head of the scoreboard.
    always @(negedge clk_in) begin
        exp_t e;
        if (sb.size() > 0 && cyc > sb[0].hi) begin
            n_cmp++; n_fail++;
            $display("FAIL missed_pulse: no cpu_ce by cycle %0d, expected in [%0d,%0d]", cyc, sb[0].lo, sb[0].hi);
            void'(sb.pop_front());
        end
        if (cpu_ce === 1'b1) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pulse: cpu_ce=1 at cycle %0d, expected 0", cyc);
            end else begin
                e = sb.pop_front();
                if (cyc < e.lo || cyc > e.hi) begin
                    n_fail++;
                    $display("FAIL pulse_time: cpu_ce at cycle %0d, expected in [%0d,%0d]", cyc, e.lo, e.hi);
                end else if (state !== e.st) begin
                    n_fail++;
                    $display("FAIL pulse_state: state=%0d during pulse, expected %0d", state, e.st);
                end
            end
            if (prev_ce) begin
                n_cmp++; n_fail++;
                $display("FAIL double_pulse: cpu_ce high two cycles at cycle %0d, expected 1 cycle", cyc);
            end
        end
        prev_ce = (cpu_ce === 1'b1);
    end

    initial begin
        rst = 1'b1; slow_clk = 1'b0; mode_run = 1'b0; step_btn = 1'b0; halt = 1'b0;

        // Reset held 3 cycles with slow_clk toggling.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            slow_clk = ~slow_clk;
            check("reset_ce", 32'(cpu_ce), 0);
            check("reset_state", 32'(state), 0);
            check("reset_count", 32'(step_count), 0);
        end
        slow_clk = 1'b0;
        tick_n(1);
        rst = 1'b0;
        tick_n(4);

        //          run  halt rises press pulses state count
        vecs[0] = '{1'b1, 1'b0, 5, 1'b0, 1'b1, 2'd1, 4'd5};  // free run
        vecs[1] = '{1'b1, 1'b0, 0, 1'b1, 1'b0, 2'd1, 4'd5};  // press in RUN ignored
        vecs[2] = '{1'b0, 1'b0, 2, 1'b0, 1'b0, 2'd0, 4'd5};  // stopped: edges ignored
        vecs[3] = '{1'b0, 1'b0, 0, 1'b1, 1'b1, 2'd0, 4'd6};  // single step
        vecs[4] = '{1'b0, 1'b0, 0, 1'b1, 1'b1, 2'd0, 4'd7};  // second step

        for (int v = 0; v < 5; v++) begin
            mode_run = vecs[v].mode_run;
            halt     = vecs[v].halt;
            tick_n(3);
            for (int r = 0; r < vecs[v].rises; r++) rise(vecs[v].pulses);
            if (vecs[v].press) press(vecs[v].pulses);
            tick_n(5);
            @(negedge clk_in);
            check($sformatf("row%0d_state", v), 32'(state), 32'(vecs[v].exp_state));
            check($sformatf("row%0d_count", v), 32'(step_count), 32'(vecs[v].exp_count));
        end

        // mode_run drops in the same cycle the tick is evaluated: pulse dropped.
        mode_run = 1'b1;
        tick_n(3);
        slow_clk = 1'b1;
        tick_n(2);
        mode_run = 1'b0;
        tick_n(8);
        slow_clk = 1'b0;
        tick_n(10);
        @(negedge clk_in);
        check("drop_state", 32'(state), 0);
        check("drop_count", 32'(step_count), 7);

        // halt arrives together with the tick: no pulse, HALTED.
        mode_run = 1'b1;
        tick_n(3);
        slow_clk = 1'b1;
        tick_n(2);
        halt = 1'b1;
        tick_n(8);
        slow_clk = 1'b0;
        tick_n(10);
        halt = 1'b0;
        @(negedge clk_in);
        check("halt_state", 32'(state), 3);
        check("halt_count", 32'(step_count), 7);

        // HALTED is sticky against edges and presses.
        for (int r = 0; r < 3; r++) rise(1'b0);
        mode_run = 1'b0;
        press(1'b0);
        @(negedge clk_in);
        check("halted_sticky_state", 32'(state), 3);
        check("halted_sticky_count", 32'(step_count), 7);

        // Reset leaves HALTED.
        rst = 1'b1;
        tick_n(3);
        @(negedge clk_in);
        check("rst2_ce", 32'(cpu_ce), 0);
        check("rst2_state", 32'(state), 0);
        check("rst2_count", 32'(step_count), 0);
        rst = 1'b0;
        tick_n(2);

        // Counter wrap on a 4-bit count.
        mode_run = 1'b1;
        tick_n(3);
        for (int r = 0; r < 15; r++) rise(1'b1);
        @(negedge clk_in);
        check("count_max", 32'(step_count), 15);
        check("run_state", 32'(state), 1);
        for (int r = 0; r < 2; r++) rise(1'b1);
        @(negedge clk_in);
        check("count_wrap", 32'(step_count), 1);

        // Reset arriving while cpu_ce is high.
        begin
            exp_t e;
            slow_clk = 1'b1;
            e.lo = cyc + 3; e.hi = cyc + 3; e.st = 2'd1;
            sb.push_back(e);
            tick_n(3);
            rst = 1'b1;
            tick_n(1);
            @(negedge clk_in);
            check("midrst_ce", 32'(cpu_ce), 0);
            check("midrst_state", 32'(state), 0);
            check("midrst_count", 32'(step_count), 0);
        end
        rst = 1'b0; slow_clk = 1'b0; mode_run = 1'b0;
        tick_n(5);
        check("scoreboard_empty", 32'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
